voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
// Sequences the shared synth voice pool: takes serialized MIDI note events and assigns each
//   note-on to one voice of the synth engine.
// Order of preference: retrigger a held voice with the same key, else a free voice, else steal
//   the oldest voice.
// Drives the engine's keys_on / note_on / cur_key_adr / cur_key_val / cur_vel_on / cur_vel_off
//   inputs; consumes voice_free from the envelope generator.
// PARAMETERS
// VOICES   32   number of synth voices in the pool
// V_WIDTH  5    voice index width, utils::clogb2(VOICES)
// AGE_W    8    width of the per-voice saturating age counter
// PORTS
// CLOCK_50     in   1        system clock; all logic on rising edge
// reset_reg_N  in   1        asynchronous active-low reset
// ev_valid     in   1        note event present
// ev_ready     out  1        allocator can accept an event; high only in IDLE
// ev_is_on     in   1        1 = note-on, 0 = note-off
// ev_key       in   7        MIDI key number
// ev_vel       in   7        MIDI velocity
// all_off      in   1        one-cycle strobe: release every voice
// voice_free   in   VOICES   1 = voice envelope finished (from env gen)
// keys_on      out  VOICES   per-voice gate; 1 = key held
// note_on      out  1        one-cycle strobe: a voice was (re)assigned
// cur_key_adr  out  V_WIDTH  voice index of the last assignment
// cur_key_val  out  8        {1'b0, key} of the last assignment
// cur_vel_on   out  8        {1'b0, vel} of the last note-on
// cur_vel_off  out  8        {1'b0, vel} of the last note-off
// stolen       out  1        one-cycle strobe coincident with note_on when a busy voice was stolen
// BEHAVIOUR
// Reset (async): state=IDLE; keys_on=0; note_on=0; stolen=0; cur_* = 0; key table=0;
//   age counters=0; ev_ready=1 once reset deasserts.
// FSM: IDLE -> SCAN -> ISSUE -> IDLE.
// IDLE
//   - ev_ready=1.
//   - On ev_valid at a clock edge: latch key/vel/type, idx=0, go to SCAN.
//   - A note-on with ev_vel==0 is treated as a note-off.
// SCAN
//   - Visits one voice per cycle, idx 0..VOICES-1; goes to ISSUE after idx==VOICES-1.
//   - Note-on tracks three candidates, each the first (lowest) index found:
//       match: keys_on[i] & key[i]==key
//       free:  voice_free[i] & ~keys_on[i]
//       old:   max age, ties to lowest index; released voices (~keys_on) win over held voices
//              regardless of age
//   - Note-off marks every i with keys_on[i] & key[i]==key.
// ISSUE (register update at the edge leaving ISSUE)
//   - Note-on: target = match if found, else free, else old; stolen=1 only for old.
//     - keys_on[target]=1; key[target]=key; age[target]=0.
//     - Every other age increments, saturating at 2^AGE_W-1.
//     - note_on=1; cur_key_adr=target; cur_key_val/cur_vel_on updated.
//   - Note-off: clear all marked keys_on bits; cur_vel_off=vel. No note_on strobe.
//     No match: no state change except cur_vel_off.
// Latency: note_on/keys_on are visible VOICES+1 edges after the accepting edge
//   (33 for VOICES=32).
// Event rate: one event per VOICES+2 cycles; ev_ready=0 while busy; upstream holds ev_valid.
// voice_free is sampled live during SCAN; a voice freeing mid-scan after its index was visited
//   is not seen until the next event.
// all_off
//   - Highest priority in any state: keys_on=0 next edge, in-flight event discarded,
//     state=IDLE, no strobes.
//   - Key table and ages are retained.
// note_on and stolen are never high for more than one cycle.
// Reset asserted mid-operation: immediate return to reset values; no partial update.
// TESTING
// - Reset, note-on key 60 vel 100, all voice_free=1 -> after 33 edges note_on=1 for one cycle,
//   cur_key_adr=0, cur_key_val=60, keys_on=32'h1, stolen=0.
// - Second note-on key 64 with voice 0 held -> cur_key_adr=1, keys_on=32'h3.
// - Note-on key 60 while voice 0 holds 60 -> retrigger: cur_key_adr=0, keys_on unchanged,
//   age[0]=0.
// - Note-off key 60 vel 40 -> keys_on[0]=0, cur_vel_off=40, no note_on.
// - Note-on key 72 vel 0 -> treated as note-off; no note_on.
// - All 32 voices held, voice_free=0, one more note-on -> oldest (voice 0) stolen:
//   stolen=1, cur_key_adr=0.
// - Same with voice 5 released but still sounding -> voice 5 chosen.
// - all_off during SCAN -> keys_on=0 next edge, no note_on, ev_ready=1 the following cycle.
// - Reset pulsed mid-SCAN -> all outputs 0 immediately, ev_ready=1 after release.

Source files
------------

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Assigns serialized MIDI note events to a pool of synth voices
//               (retrigger same key, else free voice, else steal the oldest).
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = $clog2(VOICES),
    parameter int AGE_W   = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset_reg_N,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic                ev_is_on,
    input  logic [6:0]          ev_key,
    input  logic [6:0]          ev_vel,
    input  logic                all_off,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   keys_on,
    output logic                note_on,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel_on,
    output logic [7:0]          cur_vel_off,
    output logic                stolen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [V_WIDTH-1:0] c_LAST    = V_WIDTH'(VOICES - 1);
    localparam logic [AGE_W-1:0]   c_AGE_MAX = '1;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [V_WIDTH-1:0]   r_idx;
    logic                 r_is_on;
    logic [6:0]           r_key;
    logic [6:0]           r_vel;
    logic                 r_match_found;
    logic                 r_free_found;
    logic [V_WIDTH-1:0]   r_match_idx;
    logic [V_WIDTH-1:0]   r_free_idx;
    logic [V_WIDTH-1:0]   r_old_idx;
    logic [AGE_W-1:0]     r_old_age;
    logic                 r_old_rel;
    logic [VOICES-1:0]    r_off_mask;
    logic [VOICES-1:0]    r_keys_on;
    logic [6:0]           r_key_tab [VOICES];
    logic [AGE_W-1:0]     r_age     [VOICES];
    logic                 r_note_on;
    logic                 r_stolen;
    logic [V_WIDTH-1:0]   r_cur_adr;
    logic [6:0]           r_cur_key;
    logic [6:0]           r_cur_von;
    logic [6:0]           r_cur_voff;

    logic                 w_accept;
    logic                 w_scan;
    logic                 w_issue;
    logic                 w_hit;
    logic                 w_rel;
    logic                 w_free;
    logic                 w_old_better;
    logic                 w_steal;
    logic [V_WIDTH-1:0]   w_target;

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_scan      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = ev_valid;
                if (ev_valid) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                w_scan = 1'b1;
                if (r_idx == c_LAST) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // all_off overrides every state and suppresses any pending action
        if (all_off) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_scan      = 1'b0;
            w_issue     = 1'b0;
        end
    end

    always_comb begin
        w_hit        = r_keys_on[r_idx] && (r_key_tab[r_idx] == r_key);
        w_rel        = !r_keys_on[r_idx];
        w_free       = voice_free[r_idx] && w_rel;
        // released voices beat held ones; within a class the strictly older one wins
        w_old_better = (r_idx == '0) || (w_rel && !r_old_rel) ||
                       ((w_rel == r_old_rel) && (r_age[r_idx] > r_old_age));
        w_steal      = !r_match_found && !r_free_found;
        if (r_match_found)     w_target = r_match_idx;
        else if (r_free_found) w_target = r_free_idx;
        else                   w_target = r_old_idx;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_idx         <= '0;
            r_is_on       <= 1'b0;
            r_key         <= '0;
            r_vel         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_old_rel     <= 1'b0;
            r_off_mask    <= '0;
            r_keys_on     <= '0;
            r_note_on     <= 1'b0;
            r_stolen      <= 1'b0;
            r_cur_adr     <= '0;
            r_cur_key     <= '0;
            r_cur_von     <= '0;
            r_cur_voff    <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_key_tab[i] <= '0;
                r_age[i]     <= '0;
            end
        end else begin
            r_note_on <= 1'b0;
            r_stolen  <= 1'b0;
            if (all_off) r_keys_on <= '0;

            if (w_accept) begin
                r_is_on       <= ev_is_on && (ev_vel != 7'd0);
                r_key         <= ev_key;
                r_vel         <= ev_vel;
                r_idx         <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
                r_off_mask    <= '0;
            end

            if (w_scan) begin
                r_idx <= r_idx + V_WIDTH'(1);
                if (r_is_on) begin
                    if (w_hit && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (w_free && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (w_old_better) begin
                        r_old_idx <= r_idx;
                        r_old_age <= r_age[r_idx];
                        r_old_rel <= w_rel;
                    end
                end else if (w_hit) begin
                    r_off_mask[r_idx] <= 1'b1;
                end
            end

            if (w_issue) begin
                if (r_is_on) begin
                    r_keys_on[w_target] <= 1'b1;
                    r_key_tab[w_target] <= r_key;
                    for (int i = 0; i < VOICES; i++) begin
                        if (V_WIDTH'(i) == w_target)  r_age[i] <= '0;
                        else if (r_age[i] != c_AGE_MAX) r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                    r_note_on <= 1'b1;
                    r_stolen  <= w_steal;
                    r_cur_adr <= w_target;
                    r_cur_key <= r_key;
                    r_cur_von <= r_vel;
                end else begin
                    r_keys_on  <= r_keys_on & ~r_off_mask;
                    r_cur_voff <= r_vel;
                end
            end
        end
    end

    assign ev_ready    = (r_state == S_IDLE);
    assign keys_on     = r_keys_on;
    assign note_on     = r_note_on;
    assign stolen      = r_stolen;
    assign cur_key_adr = r_cur_adr;
    assign cur_key_val = {1'b0, r_cur_key};
    assign cur_vel_on  = {1'b0, r_cur_von};
    assign cur_vel_off = {1'b0, r_cur_voff};

endmodule
`default_nettype wire
